// File: rtl/nand_core_if.sv
// Bus bundle for nand_core: instruction fetch port, data request port and debug taps.
// The core drives the master modport; the memory system (or a bench) drives the slave modport.
interface nand_core_if #(
  parameter int WIDTH = 16
);
  // Handshakes: imem_rdata is taken in FETCH on any cycle with imem_valid high.
  // dmem_re/dmem_we are held until the cycle dmem_ack is seen high, and that cycle completes the request.
  // dmem_rdata is sampled only in that cycle. Both request lines are never high together.
  logic [WIDTH-1:0] imem_addr;
  logic [15:0]      imem_rdata;
  logic             imem_valid;

  logic [WIDTH-1:0] dmem_addr;
  logic             dmem_re;
  logic             dmem_we;
  logic [WIDTH-1:0] dmem_wdata;
  logic [WIDTH-1:0] dmem_rdata;
  logic             dmem_ack;

  logic             halt;
  logic [WIDTH-1:0] dbg_a;
  logic [WIDTH-1:0] dbg_d;
  logic [2:0]       dbg_state;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  imem_valid,
    output dmem_addr,
    output dmem_re,
    output dmem_we,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack,
    output halt,
    output dbg_a,
    output dbg_d,
    output dbg_state
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output imem_valid,
    input  dmem_addr,
    input  dmem_re,
    input  dmem_we,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack,
    input  halt,
    input  dbg_a,
    input  dbg_d,
    input  dbg_state
  );
endinterface

// File: rtl/nand_core.sv
// nand_core: two-register (A/D) accumulator CPU with FETCH/LOAD/EXEC/STORE/HALT sequencing.
// Optional macro NAND_CORE_ILLEGAL_TRAP_EN: ALU words with nonzero bits [14:13] halt the core.
package nand_core_pkg;

  // bit 15 kind (0 = constant, 1 = ALU); bits [14:0] form the constant for kind=0
  typedef struct packed {
    logic       kind;
    logic [1:0] ign;
    logic       sm;
    logic       zx;
    logic       nx;
    logic       zy;
    logic       ny;
    logic       f;
    logic       no;
    logic       dst_a;
    logic       dst_d;
    logic       dst_a_star;
    logic       lt;
    logic       eq;
    logic       gt;
  } inst_word_t;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    LOAD  = 3'd1,
    EXEC  = 3'd2,
    STORE = 3'd3,
    HALT  = 3'd4
  } state_t;

endpackage

module nand_core
  import nand_core_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  nand_core_if.master  bus
);

  state_t           state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] d_q;
  inst_word_t       inst_q;
  logic [WIDTH-1:0] y_q;
  logic             re_q;
  logic             we_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] st_addr_q;

  logic [WIDTH-1:0] alu_x;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] alu_r;
  logic             r_neg;
  logic             r_zero;
  logic             jump_taken;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] const_val;
  logic             fetch_illegal;
  inst_word_t       fetch_word;

  assign fetch_word = inst_word_t'(bus.imem_rdata);
  assign const_val  = {{(WIDTH-15){1'b0}}, inst_q[14:0]};
  assign pc_inc     = pc_q + 1'b1;

`ifdef NAND_CORE_ILLEGAL_TRAP_EN
  logic halt_q;
  assign fetch_illegal = fetch_word.kind && (fetch_word.ign != 2'b00);
  assign bus.halt      = halt_q;
`else
  assign fetch_illegal = 1'b0;
  assign bus.halt      = 1'b0;
`endif

  always_comb begin
    alu_x = d_q;
    alu_y = inst_q.sm ? y_q : a_q;
    if (inst_q.zx) alu_x = '0;
    if (inst_q.nx) alu_x = ~alu_x;
    if (inst_q.zy) alu_y = '0;
    if (inst_q.ny) alu_y = ~alu_y;
    alu_r = inst_q.f ? (alu_x + alu_y) : (alu_x & alu_y);
    if (inst_q.no) alu_r = ~alu_r;
    r_neg      = alu_r[WIDTH-1];
    r_zero     = (alu_r == '0);
    jump_taken = (inst_q.lt & r_neg) |
                 (inst_q.eq & r_zero) |
                 (inst_q.gt & ~r_neg & ~r_zero);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      a_q       <= '0;
      d_q       <= '0;
      inst_q    <= '0;
      y_q       <= '0;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      st_addr_q <= '0;
`ifdef NAND_CORE_ILLEGAL_TRAP_EN
      halt_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        FETCH: begin
          if (bus.imem_valid) begin
            if (fetch_illegal) begin
              state_q <= HALT;
`ifdef NAND_CORE_ILLEGAL_TRAP_EN
              halt_q  <= 1'b1;
`endif
            end else begin
              inst_q <= fetch_word;
              if (fetch_word.kind && fetch_word.sm) begin
                state_q <= LOAD;
                re_q    <= 1'b1;
              end else begin
                state_q <= EXEC;
              end
            end
          end
        end

        LOAD: begin
          if (bus.dmem_ack) begin
            y_q     <= bus.dmem_rdata;
            re_q    <= 1'b0;
            state_q <= EXEC;
          end
        end

        EXEC: begin
          if (!inst_q.kind) begin
            a_q     <= const_val;
            pc_q    <= pc_inc;
            state_q <= FETCH;
          end else begin
            if (inst_q.dst_d) d_q <= alu_r;
            if (inst_q.dst_a) a_q <= alu_r;
            // the jump target is the A value this instruction started with
            pc_q <= jump_taken ? a_q : pc_inc;
            if (inst_q.dst_a_star) begin
              we_q      <= 1'b1;
              wdata_q   <= alu_r;
              st_addr_q <= a_q;
              state_q   <= STORE;
            end else begin
              state_q <= FETCH;
            end
          end
        end

        STORE: begin
          if (bus.dmem_ack) begin
            we_q    <= 1'b0;
            state_q <= FETCH;
          end
        end

        HALT: begin
          state_q <= HALT;
        end

        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

  // A may already hold the new result while the store is pending, so the store uses its own copy
  assign bus.dmem_addr  = (state_q == STORE) ? st_addr_q : a_q;
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_re    = re_q;
  assign bus.dmem_we    = we_q;
  assign bus.dmem_wdata = wdata_q;
  assign bus.dbg_a      = a_q;
  assign bus.dbg_d      = d_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_nand_core.sv
// Directed self-checking bench for nand_core: small instruction ROM and a data memory with programmable wait.
// Expected values are hand-computed from the instruction encodings in each scenario.
module tb_nand_core;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  nand_core_if #(.WIDTH(W)) bus ();

  nand_core #(.WIDTH(W), .RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [15:0]  rom [256];
  bit           imem_en;
  bit           force_ack;
  int           dmem_wait;
  int           wait_cnt;
  int           re_cycles;
  logic [W-1:0] dmem_val;
  bit           st_seen;
  logic [W-1:0] st_addr;
  logic [W-1:0] st_data;

  // One clock: drive inputs from current (post-edge) outputs, then advance to 1 time unit after the edge.
  task automatic step();
    bus.imem_valid = imem_en;
    bus.imem_rdata = rom[bus.imem_addr[7:0]];
    bus.dmem_rdata = dmem_val;
    bus.dmem_ack   = force_ack;
    if (bus.dmem_re) re_cycles++;
    if (bus.dmem_re || bus.dmem_we) begin
      if (wait_cnt >= dmem_wait) begin
        bus.dmem_ack = 1'b1;
        wait_cnt = 0;
        if (bus.dmem_we) begin
          st_seen = 1'b1;
          st_addr = bus.dmem_addr;
          st_data = bus.dmem_wdata;
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    imem_en = 1'b0;
    force_ack = 1'b0;
    dmem_wait = 0;
    wait_cnt = 0;
    re_cycles = 0;
    st_seen = 1'b0;
    st_addr = '0;
    st_data = '0;
    dmem_val = '0;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = '0;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = '0;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    imem_en = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.imem_valid = 1'b1;
    bus.imem_rdata = 16'h7FFF;
    bus.dmem_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.imem_addr !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", bus.imem_addr, 16'h0000); end
    checks++;
    if (bus.dbg_a !== 16'h0000 || bus.dbg_d !== 16'h0000) begin failures++; $display("FAIL reset_ad got a=%h d=%h exp=0000", bus.dbg_a, bus.dbg_d); end
    checks++;
    if (bus.dbg_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.dbg_state); end
    checks++;
    if ({bus.dmem_re, bus.dmem_we, bus.halt} !== 3'b000) begin failures++; $display("FAIL reset_ctrl got re=%b we=%b halt=%b exp=000", bus.dmem_re, bus.dmem_we, bus.halt); end
    checks++;
    if (bus.dmem_wdata !== 16'h0000) begin failures++; $display("FAIL reset_wdata got=%h exp=0000", bus.dmem_wdata); end
  endtask

  task automatic test_const();
    apply_reset();
    rom[0] = 16'h7FFF;
    step();
    checks++;
    if (bus.dbg_state !== 3'd2) begin failures++; $display("FAIL const_exec_state got=%0d exp=2", bus.dbg_state); end
    step();
    checks++;
    if (bus.dbg_a !== 16'h7FFF || bus.imem_addr !== 16'h0001) begin failures++; $display("FAIL const_load got a=%h pc=%h exp a=7fff pc=0001", bus.dbg_a, bus.imem_addr); end
  endtask

  task automatic test_alu_jump();
    apply_reset();
    rom[0] = 16'h0005;  // A=5
    rom[1] = 16'h8890;  // D=A
    rom[2] = 16'h0003;  // A=3
    rom[3] = 16'h8090;  // D=D+A
    rom[4] = 16'h0010;  // A=0x10
    rom[5] = 16'h8281;  // D;JGT
    run(8);
    checks++;
    if (bus.dbg_d !== 16'h0008) begin failures++; $display("FAIL alu_add got d=%h exp=0008", bus.dbg_d); end
    run(4);
    checks++;
    if (bus.imem_addr !== 16'h0010 || bus.dbg_a !== 16'h0010) begin failures++; $display("FAIL jgt got pc=%h a=%h exp pc=0010 a=0010", bus.imem_addr, bus.dbg_a); end
  endtask

  task automatic test_jump();
    apply_reset();
    rom[8'h00] = 16'h0020;
    rom[8'h01] = 16'h8A07;  // 0;JMP via lt|eq|gt
    rom[8'h20] = 16'h0030;
    rom[8'h21] = 16'h8E84;  // -1;JLT
    rom[8'h30] = 16'h8E83;  // -1 with eq|gt
    rom[8'h31] = 16'h8E90;  // D=-1
    rom[8'h32] = 16'h8060;  // A=!(D&A)
    rom[8'h33] = 16'h82A4;  // A=D;JLT
    run(4);
    checks++;
    if (bus.imem_addr !== 16'h0020) begin failures++; $display("FAIL jump_all_set got pc=%h exp=0020", bus.imem_addr); end
    run(4);
    checks++;
    if (bus.imem_addr !== 16'h0030) begin failures++; $display("FAIL jump_lt got pc=%h exp=0030", bus.imem_addr); end
    run(2);
    checks++;
    if (bus.imem_addr !== 16'h0031) begin failures++; $display("FAIL jump_not_taken got pc=%h exp=0031", bus.imem_addr); end
    run(2);
    checks++;
    if (bus.dbg_d !== 16'hFFFF || bus.imem_addr !== 16'h0032) begin failures++; $display("FAIL no_jump_bits got d=%h pc=%h exp d=ffff pc=0032", bus.dbg_d, bus.imem_addr); end
    run(2);
    checks++;
    if (bus.dbg_a !== 16'hFFCF) begin failures++; $display("FAIL alu_nand got a=%h exp=ffcf", bus.dbg_a); end
    run(2);
    checks++;
    if (bus.imem_addr !== 16'hFFCF || bus.dbg_a !== 16'hFFFF) begin failures++; $display("FAIL jump_old_a got pc=%h a=%h exp pc=ffcf a=ffff", bus.imem_addr, bus.dbg_a); end
  endtask

  task automatic test_load_store();
    apply_reset();
    rom[0] = 16'h0100;
    rom[1] = 16'h98A8;  // A,*A = M
    dmem_wait = 3;
    dmem_val = 16'h1234;
    run(8);
    checks++;
    if (bus.dbg_a !== 16'h1234 || bus.dbg_state !== 3'd3) begin failures++; $display("FAIL ls_exec got a=%h state=%0d exp a=1234 state=3", bus.dbg_a, bus.dbg_state); end
    checks++;
    if (bus.dmem_we !== 1'b1 || bus.dmem_re !== 1'b0 || bus.dmem_addr !== 16'h0100 || bus.dmem_wdata !== 16'h1234) begin
      failures++;
      $display("FAIL ls_store_req got we=%b re=%b addr=%h wdata=%h exp we=1 re=0 addr=0100 wdata=1234", bus.dmem_we, bus.dmem_re, bus.dmem_addr, bus.dmem_wdata);
    end
    run(4);
    checks++;
    if (re_cycles !== 4) begin failures++; $display("FAIL ls_re_cycles got=%0d exp=4", re_cycles); end
    checks++;
    if (!st_seen || st_addr !== 16'h0100 || st_data !== 16'h1234) begin failures++; $display("FAIL ls_store_done got seen=%b addr=%h data=%h exp seen=1 addr=0100 data=1234", st_seen, st_addr, st_data); end
    checks++;
    if (bus.imem_addr !== 16'h0002 || bus.dbg_state !== 3'd0 || bus.dmem_we !== 1'b0) begin failures++; $display("FAIL ls_return got pc=%h state=%0d we=%b exp pc=0002 state=0 we=0", bus.imem_addr, bus.dbg_state, bus.dmem_we); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    rom[0] = 16'h0100;
    rom[1] = 16'h98A8;
    dmem_wait = 0;
    dmem_val = 16'h0ABC;
    run(5);
    checks++;
    if (bus.dbg_state !== 3'd3) begin failures++; $display("FAIL b2b_store_state got=%0d exp=3", bus.dbg_state); end
    step();
    checks++;
    if (bus.dbg_state !== 3'd0 || bus.imem_addr !== 16'h0002 || bus.dbg_a !== 16'h0ABC) begin failures++; $display("FAIL b2b_latency got state=%0d pc=%h a=%h exp state=0 pc=0002 a=0abc", bus.dbg_state, bus.imem_addr, bus.dbg_a); end
  endtask

  task automatic test_pc_wrap();
    apply_reset();
    rom[8'h00] = 16'h8EA0;  // A=-1
    rom[8'h01] = 16'h8A07;  // 0;JMP
    rom[8'hFF] = 16'h8A10;  // D=0
    run(4);
    checks++;
    if (bus.imem_addr !== 16'hFFFF) begin failures++; $display("FAIL wrap_setup got pc=%h exp=ffff", bus.imem_addr); end
    run(2);
    checks++;
    if (bus.imem_addr !== 16'h0000) begin failures++; $display("FAIL pc_wrap got pc=%h exp=0000", bus.imem_addr); end
  endtask

  task automatic test_stall_ignore();
    apply_reset();
    rom[0] = 16'h0123;
    imem_en = 1'b0;
    force_ack = 1'b1;
    run(3);
    checks++;
    if (bus.imem_addr !== 16'h0000 || bus.dbg_state !== 3'd0 || bus.dbg_a !== 16'h0000) begin failures++; $display("FAIL fetch_stall got pc=%h state=%0d a=%h exp pc=0000 state=0 a=0000", bus.imem_addr, bus.dbg_state, bus.dbg_a); end
    imem_en = 1'b1;
    step();
    imem_en = 1'b0;
    step();
    checks++;
    if (bus.dbg_a !== 16'h0123 || bus.imem_addr !== 16'h0001) begin failures++; $display("FAIL valid_outside_fetch got a=%h pc=%h exp a=0123 pc=0001", bus.dbg_a, bus.imem_addr); end
    checks++;
    if (bus.dmem_re !== 1'b0 || bus.dmem_we !== 1'b0) begin failures++; $display("FAIL stray_ack got re=%b we=%b exp 00", bus.dmem_re, bus.dmem_we); end
    force_ack = 1'b0;
  endtask

  task automatic test_reset_store();
    apply_reset();
    rom[0] = 16'h0040;
    rom[1] = 16'h8E98;  // D,*A = -1
    dmem_wait = 50;
    run(6);
    checks++;
    if (bus.dmem_we !== 1'b1 || bus.dmem_wdata !== 16'hFFFF || bus.dbg_d !== 16'hFFFF) begin failures++; $display("FAIL store_wait got we=%b wdata=%h d=%h exp we=1 wdata=ffff d=ffff", bus.dmem_we, bus.dmem_wdata, bus.dbg_d); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.dmem_we !== 1'b0 || bus.dmem_wdata !== 16'h0000) begin failures++; $display("FAIL async_drop got we=%b wdata=%h exp we=0 wdata=0000", bus.dmem_we, bus.dmem_wdata); end
    checks++;
    if (bus.imem_addr !== 16'h0000 || bus.dbg_a !== 16'h0000 || bus.dbg_d !== 16'h0000 || bus.dbg_state !== 3'd0) begin
      failures++;
      $display("FAIL async_regs got pc=%h a=%h d=%h state=%0d exp 0000 0000 0000 0", bus.imem_addr, bus.dbg_a, bus.dbg_d, bus.dbg_state);
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    rom[0] = 16'h0007;
    rom[1] = 16'hE000;
    run(4);
`ifdef NAND_CORE_ILLEGAL_TRAP_EN
    checks++;
    if (bus.halt !== 1'b1 || bus.dbg_state !== 3'd4) begin failures++; $display("FAIL trap_halt got halt=%b state=%0d exp halt=1 state=4", bus.halt, bus.dbg_state); end
    run(3);
    checks++;
    if (bus.imem_addr !== 16'h0001 || bus.dbg_a !== 16'h0007 || bus.dbg_d !== 16'h0000 || bus.dbg_state !== 3'd4) begin
      failures++;
      $display("FAIL trap_frozen got pc=%h a=%h d=%h state=%0d exp pc=0001 a=0007 d=0000 state=4", bus.imem_addr, bus.dbg_a, bus.dbg_d, bus.dbg_state);
    end
`else
    checks++;
    if (bus.halt !== 1'b0 || bus.imem_addr !== 16'h0002) begin failures++; $display("FAIL ignored_bits got halt=%b pc=%h exp halt=0 pc=0002", bus.halt, bus.imem_addr); end
    checks++;
    if (bus.dbg_a !== 16'h0007 || bus.dbg_d !== 16'h0000) begin failures++; $display("FAIL ignored_bits_regs got a=%h d=%h exp a=0007 d=0000", bus.dbg_a, bus.dbg_d); end
`endif
  endtask

  initial begin
    test_reset();
    test_const();
    test_alu_jump();
    test_jump();
    test_load_store();
    test_back_to_back();
    test_pc_wrap();
    test_stall_ignore();
    test_reset_store();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
